wb_cmd_slave: RTL

//  Wishbone b4 responder (S side) on the NEORV32 external bus. Provides a small

---
 rtl/wb_cmd_slave.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_slave.sv
`default_nettype none
// ============================================================================
// Module      : wb_cmd_slave
// Description : Wishbone b4 responder with a small control register bank
//               (ID, CTRL, STATUS, SCRATCH) and a DEPTH-entry command FIFO
//               drained by a downstream valid/ready consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_cmd_slave #(
  parameter int            AW          = 32,
  parameter int            DW          = 32,
  parameter int            TW          = 3,
  parameter logic [AW-1:0] BASE        = 32'h9000_0000,
  parameter logic [31:0]   ID_VALUE    = 32'h4843_0001,
  parameter int            WAIT_STATES = 0,
  parameter int            DEPTH       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TW-1:0]   tag,
  input  logic [AW-1:0]   adr,
  input  logic            stb,
  input  logic            cyc,
  input  logic [DW-1:0]   data_i,
  output logic [DW-1:0]   data_o,
  input  logic [DW/8-1:0] sel,
  input  logic            we,
  input  logic            lock,
  output logic            ack,
  output logic            err,
  output logic [31:0]     ctrl_o,
  output logic            cmd_valid,
  output logic [31:0]     cmd_data,
  input  logic            cmd_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  // Last wait-counter value before the response; unused when WAIT_STATES==0.
  localparam logic [3:0] CNT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] OFF_ID     = 3'd0;
  localparam logic [2:0] OFF_CTRL   = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_CMD    = 3'd3;
  localparam logic [2:0] OFF_SCR    = 3'd4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept, commit;

  logic [2:0]    off_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [31:0]   wdat_q;

  logic [2:0]    c_off;
  logic          c_we;
  logic [3:0]    c_sel;
  logic [31:0]   c_dat;

  logic          hit, full, empty, pop, cmd_wr, push_bad, push, resp_err, ovf_clr;
  logic [31:0]   rd_val, status_val;

  logic          ack_q, err_q, ovf_q;
  logic [31:0]   rdata_q, ctrl_q, scratch_q;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] count_q, count_d;

  logic          unused_ok;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  assign hit = cyc & stb & (adr[AW-1:5] == BASE[AW-1:5]);

  // With zero wait states the commit edge is the accept edge, so the live bus
  // values are used; otherwise the copy latched at accept is used.
  assign c_off = (state_q == S_IDLE) ? adr[4:2] : off_q;
  assign c_we  = (state_q == S_IDLE) ? we       : we_q;
  assign c_sel = (state_q == S_IDLE) ? sel      : sel_q;
  assign c_dat = (state_q == S_IDLE) ? data_i   : wdat_q;

  assign empty    = (count_q == '0);
  assign full     = (count_q == LW'(DEPTH));
  assign pop      = ~empty & cmd_ready;
  // Full is judged before any same-edge pop: a full FIFO always rejects.
  assign cmd_wr   = commit & c_we & (c_off == OFF_CMD);
  assign push_bad = full | (c_sel != 4'hF);
  assign push     = cmd_wr & ~push_bad;
  assign resp_err = (c_off > OFF_SCR) | (c_we & (c_off == OFF_CMD) & push_bad);
  assign ovf_clr  = commit & c_we & (c_off == OFF_STATUS) & c_sel[2] & c_dat[16];

  // Read-data multiplexer and STATUS word assembly
  always_comb begin
    status_val            = '0;
    status_val[0]         = empty;
    status_val[1]         = full;
    status_val[8 +: LW]   = count_q;
    status_val[16]        = ovf_q;
    rd_val                = '0;
    unique case (c_off)
      OFF_ID:     rd_val = ID_VALUE;
      OFF_CTRL:   rd_val = ctrl_q;
      OFF_STATUS: rd_val = status_val;
      OFF_SCR:    rd_val = scratch_q;
      default:    rd_val = '0;
    endcase
  end

  // Transfer FSM next-state: accept, optional wait, single response cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!cyc) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request at accept for use at a later commit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q  <= '0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      wdat_q <= '0;
    end else if (accept) begin
      off_q  <= adr[4:2];
      we_q   <= we;
      sel_q  <= sel;
      wdat_q <= data_i;
    end
  end

  // Response pulses and read data, loaded on the edge entering RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= commit & ~resp_err;
      err_q <= commit & resp_err;
      if (commit & ~c_we & ~resp_err) rdata_q <= rd_val;
    end
  end

  // Control, scratch and sticky overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (commit & c_we & (c_off == OFF_CTRL)) ctrl_q    <= byte_merge(ctrl_q, c_dat, c_sel);
      if (commit & c_we & (c_off == OFF_SCR))  scratch_q <= byte_merge(scratch_q, c_dat, c_sel);
      if (ovf_clr)                             ovf_q     <= 1'b0;
      else if (cmd_wr & push_bad)              ovf_q     <= 1'b1;
    end
  end

  // FIFO occupancy follows push/pop; simultaneous push and pop keeps the level
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= c_dat;
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign data_o    = rdata_q;
  assign ctrl_o    = ctrl_q;
  assign cmd_valid = ~empty;
  assign cmd_data  = mem_q[rptr_q];

  // Tag, lock and the byte-lane address bits carry no meaning here
  assign unused_ok = ^{tag, lock, adr[1:0]};

endmodule
`default_nettype wire
